// File: rtl/decrypt_checker.sv
// decrypt_checker: XORs ciphertext ROM bytes with PRGA keystream bytes,
// writes the plaintext to RAM and flags whether every byte is 'a'..'z' or space.
module decrypt_checker #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter logic [7:0]  CHAR_LO = 8'h61,
  parameter logic [7:0]  CHAR_HI = 8'h7A,
  parameter logic [7:0]  CHAR_SP = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ks_valid,
  input  logic [7:0]        ks_byte,
  output logic              ks_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              success,
  output logic              failure
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROMWAIT,
    S_KSWAIT,
    S_WRITE,
    S_FAIL,
    S_PASS
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_k;
  logic              r_ks_ready;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic              r_ram_wren;
  logic              r_success;
  logic              r_failure;
  logic              w_xfer;
  logic              w_legal;

  // Keystream handshake; r_ks_ready is high exactly while in KSWAIT.
  assign w_xfer  = (r_state == S_KSWAIT) && r_ks_ready && ks_valid;

  // The latched plaintext byte (held in r_ram_data) is legal text.
  assign w_legal = ((r_ram_data >= CHAR_LO) && (r_ram_data <= CHAR_HI)) ||
                   (r_ram_data == CHAR_SP);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_ROMWAIT;
      S_ROMWAIT: w_state_nxt = S_KSWAIT;
      S_KSWAIT:  if (w_xfer) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (!w_legal) begin
          w_state_nxt = S_FAIL;
        end else if (r_k == LAST_K) begin
          w_state_nxt = S_PASS;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FAIL:    w_state_nxt = S_FAIL;
      S_PASS:    w_state_nxt = S_PASS;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, byte index and plaintext latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k        <= '0;
      r_ks_ready <= 1'b0;
      r_rom_addr <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_wren <= 1'b0;
      r_success  <= 1'b0;
      r_failure  <= 1'b0;
    end else begin
      r_ks_ready <= (w_state_nxt == S_KSWAIT);
      r_success  <= (w_state_nxt == S_PASS);
      r_failure  <= (w_state_nxt == S_FAIL);
      r_ram_wren <= w_xfer;
      if (r_state == S_FETCH) begin
        r_rom_addr <= r_k;
      end
      if (w_xfer) begin
        r_ram_addr <= r_k;
        r_ram_data <= ks_byte ^ rom_q;
      end
      if ((r_state == S_WRITE) && w_legal && (r_k != LAST_K)) begin
        r_k <= r_k + ADDR_W'(1);
      end
    end
  end

  assign ks_ready = r_ks_ready;
  assign rom_addr = r_rom_addr;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign ram_wren = r_ram_wren;
  assign success  = r_success;
  assign failure  = r_failure;

endmodule

// File: tb/tb_decrypt_checker.sv
// Self-checking bench for decrypt_checker: ROM and PRGA models plus a write scoreboard.
module tb_decrypt_checker;

  typedef struct {
    logic [7:0] p;
    bit         legal;
  } vec_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ks_valid;
  logic [7:0] ks_byte;
  logic       ks_ready;
  logic [4:0] rom_addr;
  logic [7:0] rom_q;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic       success;
  logic       failure;

  logic [7:0] rom_mem [32];
  logic [7:0] ks_mem  [32];
  logic [7:0] plain   [32];
  logic [5:0] ks_idx;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  n_writes = 0;
  int  last_wr_cyc = 0;
  wr_t exp_q[$];
  vec_t vecs [7];

  decrypt_checker dut (
    .clk      (clk),
    .reset    (reset),
    .ks_valid (ks_valid),
    .ks_byte  (ks_byte),
    .ks_ready (ks_ready),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .success  (success),
    .failure  (failure)
  );

  always #5 clk = ~clk;

  // Synchronous ciphertext ROM, one-cycle latency.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // PRGA model: presents the next keystream byte, advances on each transfer.
  always @(posedge clk or negedge reset) begin
    if (!reset) ks_idx <= '0;
    else if (ks_valid && ks_ready) ks_idx <= ks_idx + 6'd1;
  end
  assign ks_byte = ks_mem[ks_idx[4:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any RAM write seen there.
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (reset === 1'b1 && ram_wren === 1'b1) begin
      n_writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_data), 32'(e.data));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ks_ready"}, 32'(ks_ready), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, "_success"},  32'(success),  32'd0);
    check({tag, "_failure"},  32'(failure),  32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    ks_valid = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("rst");
    step();
    n_writes = 0;
    reset = 1'b1;
  endtask

  task automatic set_plain_legal();
    for (int i = 0; i < 32; i++)
      plain[i] = (i % 6 == 5) ? 8'h20 : 8'h61 + 8'(i % 26);
  endtask

  task automatic load_msg();
    for (int i = 0; i < 32; i++) rom_mem[i] = plain[i] ^ ks_mem[i];
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: 5'(i), data: plain[i]});
  endtask

  // Run until success/failure, bounded; also checks the flag latency after the last write.
  task automatic run_done(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (success === 1'b1 || failure === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    if (done) check("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
  endtask

  task automatic run_until_writes(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && n_writes < n; i++) step();
    check("writes_reached", 32'(n_writes), 32'(n));
  endtask

  initial begin
    logic [4:0] held_addr;

    vecs[0] = '{p: 8'h60, legal: 1'b0};
    vecs[1] = '{p: 8'h7B, legal: 1'b0};
    vecs[2] = '{p: 8'h1F, legal: 1'b0};
    vecs[3] = '{p: 8'h21, legal: 1'b0};
    vecs[4] = '{p: 8'h61, legal: 1'b1};
    vecs[5] = '{p: 8'h7A, legal: 1'b1};
    vecs[6] = '{p: 8'h20, legal: 1'b1};

    for (int i = 0; i < 32; i++) ks_mem[i] = 8'($urandom);

    // 1: full legal message, continuous keystream
    set_plain_legal();
    load_msg();
    do_reset();
    push_exp(32);
    ks_valid = 1'b1;
    run_done(400);
    check("t1_success", 32'(success), 32'd1);
    check("t1_failure", 32'(failure), 32'd0);
    check("t1_writes", 32'(n_writes), 32'd32);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("t1_success_held", 32'(success), 32'd1);
    check("t1_ks_ready_off", 32'(ks_ready), 32'd0);

    // 2: byte 5 decodes to 'A'
    set_plain_legal();
    plain[5] = 8'h41;
    load_msg();
    do_reset();
    push_exp(6);
    ks_valid = 1'b1;
    run_done(100);
    check("t2_failure", 32'(failure), 32'd1);
    check("t2_success", 32'(success), 32'd0);
    check("t2_writes", 32'(n_writes), 32'd6);
    held_addr = rom_addr;
    for (int i = 0; i < 6; i++) step();
    check("t2_failure_held", 32'(failure), 32'd1);
    check("t2_ks_ready", 32'(ks_ready), 32'd0);
    check("t2_rom_addr_frozen", 32'(rom_addr), 32'(held_addr));
    check("t2_rom_addr_val", 32'(rom_addr), 32'd5);
    check("t2_writes_after", 32'(n_writes), 32'd6);

    // 3: single-byte boundary table at k=0
    for (int v = 0; v < 7; v++) begin
      set_plain_legal();
      plain[0] = vecs[v].p;
      load_msg();
      do_reset();
      ks_valid = 1'b1;
      if (vecs[v].legal) begin
        push_exp(2);
        run_until_writes(2, 20);
        check("t3_legal_no_fail", 32'(failure), 32'd0);
      end else begin
        push_exp(1);
        run_done(20);
        check("t3_illegal_fail", 32'(failure), 32'd1);
        check("t3_illegal_writes", 32'(n_writes), 32'd1);
      end
    end

    // 4: keystream stall at k=3
    set_plain_legal();
    load_msg();
    do_reset();
    push_exp(32);
    ks_valid = 1'b1;
    run_until_writes(3, 40);
    ks_valid = 1'b0;
    for (int i = 0; i < 10 && ks_ready !== 1'b1; i++) step();
    check("t4_in_kswait", 32'(ks_ready), 32'd1);
    check("t4_rom_addr", 32'(rom_addr), 32'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_stall_ready", 32'(ks_ready), 32'd1);
      check("t4_stall_nowrite", 32'(n_writes), 32'd3);
    end
    ks_valid = 1'b1;
    step();
    check("t4_write_next", 32'(ram_wren), 32'd1);
    check("t4_write_addr", 32'(ram_addr), 32'd3);
    run_done(400);
    check("t4_success", 32'(success), 32'd1);
    check("t4_writes", 32'(n_writes), 32'd32);

    // 5: reset mid-KSWAIT at k=12, then full re-decode
    set_plain_legal();
    load_msg();
    do_reset();
    push_exp(32);
    ks_valid = 1'b1;
    run_until_writes(12, 200);
    for (int i = 0; i < 10 && ks_ready !== 1'b1; i++) step();
    check("t5_kswait_k12", 32'(rom_addr), 32'd12);
    reset = 1'b0;
    #1;
    check_all_zero("t5_async");
    exp_q.delete();
    step();
    n_writes = 0;
    reset = 1'b1;
    push_exp(32);
    step();
    step();
    check("t5_rom_addr_restart", 32'(rom_addr), 32'd0);
    run_done(400);
    check("t5_success", 32'(success), 32'd1);
    check("t5_writes", 32'(n_writes), 32'd32);

    // 6: only the last byte is illegal
    set_plain_legal();
    plain[31] = 8'h5B;
    load_msg();
    do_reset();
    push_exp(32);
    ks_valid = 1'b1;
    run_done(400);
    check("t6_failure", 32'(failure), 32'd1);
    check("t6_success", 32'(success), 32'd0);
    check("t6_writes", 32'(n_writes), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
